// File: rtl/regfile_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sequencer_pkg
// Description : Shared opcodes, FSM state encoding and instruction field
//               positions for the register-file micro-sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_sequencer_pkg;

    // Opcode field values
    typedef enum logic [1:0] {
        OP_LDI = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_MOV = 2'b11
    } opcode_t;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ_A = 3'd1,
        ST_READ_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WRITE  = 3'd4
    } state_t;

    // Instruction field LSB positions: [7:6] op, [5:4] rd, [3:2] ra, [1:0] rb, [3:0] imm
    localparam int c_OPC_LSB = 6;
    localparam int c_OPC_W   = 2;
    localparam int c_RD_LSB  = 4;
    localparam int c_RA_LSB  = 2;
    localparam int c_RB_LSB  = 0;
    localparam int c_IMM_LSB = 0;

endpackage : regfile_sequencer_pkg
`default_nettype wire

// File: rtl/regfile_sequencer_alu_4.sv
`default_nettype none
// ============================================================================
// Module      : alu_4
// Description : Combinational ALU for the sequencer: load-immediate, add with
//               carry-out, subtract with borrow-out, and move.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_4
    import regfile_sequencer_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  opcode_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] y,
    output logic              cout
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    // One extra bit catches the carry; for subtraction it is the borrow (a < b)
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    // Select the result and flag for the current opcode
    always_comb begin
        y    = '0;
        cout = 1'b0;
        unique case (op)
            OP_LDI: y = imm;
            OP_ADD: begin
                y    = w_sum[DATA_W-1:0];
                cout = w_sum[DATA_W];
            end
            OP_SUB: begin
                y    = w_diff[DATA_W-1:0];
                cout = w_diff[DATA_W];
            end
            OP_MOV: y = a;
            default: y = '0;
        endcase
    end

endmodule : alu_4
`default_nettype wire

// File: rtl/register_file_4x4.sv
`default_nettype none
// ============================================================================
// Module      : register_file_4x4
// Description : Four-entry register file with one synchronous write port and
//               one combinational read port; asynchronous active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_4x4 #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              write,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic [ADDR_W-1:0] r_address,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Storage: cleared asynchronously, written on the rising edge
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_mem <= '{default: '0};
        end else if (write) begin
            r_mem[wr_address] <= wdata;
        end
    end

    assign rdata = r_mem[r_address];

endmodule : register_file_4x4
`default_nettype wire

// File: rtl/regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sequencer
// Description : Micro-sequencer in front of a 4x4 register file. Accepts one
//               8-bit instruction per handshake, reads operands serially
//               through the single read port, executes on alu_4 and writes
//               the result back. Result, carry, zero and a done pulse are
//               exported.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sequencer
    import regfile_sequencer_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int ADDR_W  = 2,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               rf_write,
    output logic [ADDR_W-1:0]  rf_wr_address,
    output logic [ADDR_W-1:0]  rf_r_address,
    output logic [DATA_W-1:0]  rf_wdata,
    input  logic [DATA_W-1:0]  rf_rdata,
    output logic [DATA_W-1:0]  result,
    output logic               carry,
    output logic               zero,
    output logic               done
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_idle;
    logic              w_accept;
    opcode_t           w_instr_op;

    opcode_t           r_op;
    logic [ADDR_W-1:0] r_rd;
    logic [ADDR_W-1:0] r_ra;
    logic [ADDR_W-1:0] r_rb;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_alu_q;
    logic [DATA_W-1:0] r_result;
    logic              r_carry;
    logic              r_zero;
    logic              r_done;

    logic [DATA_W-1:0] w_alu_y;
    logic              w_alu_cout;

    assign w_instr_op = opcode_t'(instr[c_OPC_LSB +: c_OPC_W]);

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and register-file port decode; ports depend on state and latched fields only
    always_comb begin
        w_state_nxt   = r_state;
        w_idle        = 1'b0;
        w_accept      = 1'b0;
        rf_write      = 1'b0;
        rf_wr_address = '0;
        rf_r_address  = '0;
        rf_wdata      = '0;
        unique case (r_state)
            ST_IDLE: begin
                w_idle = 1'b1;
                if (instr_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (w_instr_op == OP_LDI) ? ST_EXEC : ST_READ_A;
                end
            end
            ST_READ_A: begin
                rf_r_address = r_ra;
                w_state_nxt  = (r_op == OP_MOV) ? ST_EXEC : ST_READ_B;
            end
            ST_READ_B: begin
                rf_r_address = r_rb;
                w_state_nxt  = ST_EXEC;
            end
            ST_EXEC: begin
                w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                rf_write      = 1'b1;
                rf_wr_address = r_rd;
                rf_wdata      = r_alu_q;
                w_state_nxt   = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Ready is masked while clr is held so every output reads 0 during reset
    assign instr_ready = w_idle & clr;

    alu_4 #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op   (r_op),
        .a    (r_op_a),
        .b    (r_op_b),
        .imm  (r_imm),
        .y    (w_alu_y),
        .cout (w_alu_cout)
    );

    // Instruction latch, operand capture, execute and write-back registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_op     <= OP_LDI;
            r_rd     <= '0;
            r_ra     <= '0;
            r_rb     <= '0;
            r_imm    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_alu_q  <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == ST_WRITE);
            if (w_accept) begin
                r_op  <= w_instr_op;
                r_rd  <= instr[c_RD_LSB  +: ADDR_W];
                r_ra  <= instr[c_RA_LSB  +: ADDR_W];
                r_rb  <= instr[c_RB_LSB  +: ADDR_W];
                r_imm <= instr[c_IMM_LSB +: DATA_W];
            end
            if (r_state == ST_READ_A) begin
                r_op_a <= rf_rdata;
            end
            if (r_state == ST_READ_B) begin
                r_op_b <= rf_rdata;
            end
            if (r_state == ST_EXEC) begin
                r_alu_q <= w_alu_y;
                r_zero  <= (w_alu_y == '0);
                // LDI and MOV leave the previous carry untouched
                if ((r_op == OP_ADD) || (r_op == OP_SUB)) begin
                    r_carry <= w_alu_cout;
                end
            end
            if (r_state == ST_WRITE) begin
                r_result <= r_alu_q;
            end
        end
    end

    assign result = r_result;
    assign carry  = r_carry;
    assign zero   = r_zero;
    assign done   = r_done;

endmodule : regfile_sequencer
`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sequencer
// Description : Self-checking bench: sequencer wired to register_file_4x4,
//               directed scenarios followed by random instructions, all
//               compared against an architectural model of the four
//               registers and the flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sequencer;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       instr_valid = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       instr_ready;
    logic       rf_write;
    logic [1:0] rf_wr_address;
    logic [1:0] rf_r_address;
    logic [3:0] rf_wdata;
    logic [3:0] rf_rdata;
    logic [3:0] result;
    logic       carry;
    logic       zero;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Architectural model
    logic [3:0] m_reg [4];
    logic       m_carry;
    int         m_writes;
    int         wr_seen;

    always #5 clk = ~clk;

    regfile_sequencer #(
        .DATA_W  (4),
        .ADDR_W  (2),
        .INSTR_W (8)
    ) u_dut (
        .clk           (clk),
        .clr           (clr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .rf_write      (rf_write),
        .rf_wr_address (rf_wr_address),
        .rf_r_address  (rf_r_address),
        .rf_wdata      (rf_wdata),
        .rf_rdata      (rf_rdata),
        .result        (result),
        .carry         (carry),
        .zero          (zero),
        .done          (done)
    );

    register_file_4x4 #(
        .DATA_W (4),
        .ADDR_W (2)
    ) u_rf (
        .clk        (clk),
        .clr        (clr),
        .write      (rf_write),
        .wr_address (rf_wr_address),
        .r_address  (rf_r_address),
        .wdata      (rf_wdata),
        .rdata      (rf_rdata)
    );

    // Every register-file write strobe seen at a clock edge
    always @(posedge clk) begin
        if (rf_write) wr_seen++;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] mk(input int op, input int rd, input int ra, input int rb);
        logic [7:0] v;
        v = {op[1:0], rd[1:0], ra[1:0], rb[1:0]};
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 4'h0;
        m_carry = 1'b0;
    endtask

    // Issue one instruction from an idle negedge and follow it to its done cycle.
    // With hold set, instr_valid stays high carrying nxt during the busy cycles.
    task automatic send(input logic [7:0] ins, input bit hold, input logic [7:0] nxt);
        int op, rd, ra, rb, a, b, y, lat, exp_ra;
        bit c;
        op = ins[7:6]; rd = ins[5:4]; ra = ins[3:2]; rb = ins[1:0];
        a  = m_reg[ra]; b = m_reg[rb];
        c  = m_carry;
        case (op)
            0: begin y = ins[3:0];          lat = 2; end
            1: begin y = (a + b) % 16;      c = (a + b) > 15; lat = 4; end
            2: begin y = (a - b + 16) % 16; c = (a < b);      lat = 4; end
            default: begin y = a;           lat = 3; end
        endcase

        check_eq("ready_idle", instr_ready, 1);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold) begin
            instr = nxt;
        end else begin
            instr_valid = 1'b0;
            instr       = 8'($urandom);
        end

        for (int m = 0; m <= lat; m++) begin
            @(negedge clk);
            if (m < lat) begin
                check_eq("ready_busy", instr_ready, 0);
                check_eq("done_early", done, 0);
                if (m == 0 && op != 0)                exp_ra = ra;
                else if (m == 1 && (op == 1 || op == 2)) exp_ra = rb;
                else                                   exp_ra = 0;
                check_eq("r_address", rf_r_address, exp_ra);
                if (m == lat - 1) begin
                    check_eq("rf_write", rf_write, 1);
                    check_eq("wr_address", rf_wr_address, rd);
                    check_eq("wdata", rf_wdata, y);
                end else begin
                    check_eq("rf_write_idle", rf_write, 0);
                end
            end else begin
                check_eq("done", done, 1);
                check_eq("result", result, y);
                check_eq("carry", carry, c);
                check_eq("zero", zero, (y == 0));
                check_eq("rf_write_after", rf_write, 0);
            end
        end

        m_reg[rd] = 4'(y);
        m_carry   = c;
        m_writes++;
    endtask

    task automatic send1(input logic [7:0] ins);
        send(ins, 1'b0, 8'h00);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"}, instr_ready, 0);
        check_eq({tag, "_write"}, rf_write, 0);
        check_eq({tag, "_wa"}, rf_wr_address, 0);
        check_eq({tag, "_ra"}, rf_r_address, 0);
        check_eq({tag, "_wd"}, rf_wdata, 0);
        check_eq({tag, "_res"}, result, 0);
        check_eq({tag, "_c"}, carry, 0);
        check_eq({tag, "_z"}, zero, 0);
        check_eq({tag, "_done"}, done, 0);
    endtask

    initial begin
        logic [7:0] ins;
        logic [7:0] pend;
        bit         have_pend;
        bit         hold;
        int         wr_before;

        m_writes = 0;
        wr_seen  = 0;
        model_reset();

        // Power-on reset
        repeat (3) @(negedge clk);
        check_all_zero("por");
        clr = 1'b1;
        #1;
        check_eq("por_ready", instr_ready, 1);
        @(negedge clk);

        // LDI r2,9
        send1(mk(0, 2, 2, 1));
        // LDI r0=7, LDI r1=12, ADD r3,r0,r1 -> 3, carry 1
        send1(mk(0, 0, 1, 3));
        send1(mk(0, 1, 3, 0));
        send1(mk(1, 3, 0, 1));
        // SUB cases: zero result, rd aliasing an operand, borrow
        send1(mk(0, 0, 1, 1));
        send1(mk(0, 1, 1, 1));
        send1(mk(2, 2, 0, 1));
        send1(mk(2, 2, 1, 2));
        send1(mk(0, 1, 2, 1));
        send1(mk(2, 3, 2, 1));
        // MOV r1,r3 with r3=6; carry from the borrow above must survive
        send1(mk(0, 3, 1, 2));
        send1(mk(3, 1, 3, 0));
        // ADD r0,r0,r0 with r0=8 while the next instruction is held valid
        send1(mk(0, 0, 2, 0));
        send(mk(1, 0, 0, 0), 1'b1, mk(0, 2, 0, 3));
        send1(mk(0, 2, 0, 3));

        // Reset during READ_B of an ADD
        send1(mk(0, 0, 1, 1));
        wr_before   = wr_seen;
        instr       = mk(1, 3, 0, 0);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        clr = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        check_eq("rst_no_write", wr_seen, wr_before);
        clr = 1'b1;
        #1;
        check_eq("rst_rel_ready", instr_ready, 1);
        check_eq("rst_rf_r0", rf_rdata, 0);
        model_reset();
        @(negedge clk);

        // Random instruction stream, occasionally holding the next one valid
        have_pend = 1'b0;
        pend      = 8'h00;
        for (int i = 0; i < 80; i++) begin
            ins  = have_pend ? pend : 8'($urandom);
            hold = ($urandom_range(0, 3) == 0);
            pend = 8'($urandom);
            send(ins, hold, pend);
            have_pend = hold;
        end
        if (have_pend) send1(pend);

        check_eq("write_count", wr_seen, m_writes);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regfile_sequencer
`default_nettype wire
